serial_parity_checker: RTL
==========================

Name: serial_parity_checker

Overview:
Receive end of the team's XOR-parity serial link. Deserialises one frame per transfer: start bit, DATA_W data bits LSB first, one parity bit, one stop bit. Bits arrive one per rx_valid strobe. The block recomputes parity by XOR-accumulating the data bits and flags parity and framing errors. It sits between the bit-level line sampler and the byte-wide consumer.

Parameters:
DATA_W, 8, number of data bits per frame (legal range 1..16)
ODD_PARITY, 0, 0 = even parity (XOR of data and parity bit must be 0); 1 = odd parity (must be 1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
rx_bit  input  1  serial line bit; sampled only when rx_valid=1
rx_valid  input  1  bit strobe; one frame bit per asserted cycle; gaps allowed
data_out  output  DATA_W  last received data word; held until the next frame completes
data_valid  output  1  one-cycle pulse: data_out, parity_err and frame_err are updated
parity_err  output  1  parity mismatch on the last frame; held with data_out
frame_err  output  1  stop bit was 0 on the last frame; held with data_out
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE.
  - data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0.
  - Shift register, bit counter and XOR accumulator are cleared.
  - rst has priority over every other event.
- States: IDLE, DATA, PARITY, STOP. The state advances only on cycles with rx_valid=1. When rx_valid=0, all state and registers hold.
- IDLE:
  - rx_valid with rx_bit=0 is a start bit. Clear shift register, counter and accumulator, then go to DATA.
  - rx_valid with rx_bit=1 is line idle. Ignore it and stay in IDLE.
- DATA:
  - Each rx_valid writes rx_bit into shift register position cnt (LSB first), sets acc <= acc ^ rx_bit, and increments cnt.
  - On the DATA_W-th bit (cnt = DATA_W-1), go to PARITY.
- PARITY: on rx_valid, latch perr = acc ^ rx_bit ^ ODD_PARITY, then go to STOP.
- STOP: on rx_valid, register the frame outputs and go to IDLE:
  - data_out <= shift register
  - parity_err <= perr
  - frame_err <= ~rx_bit
  - data_valid <= 1
- Latency: data_valid is high in the cycle after the clk edge that samples the stop bit. It stays high for exactly one cycle.
- A frame with an error still delivers data_out and pulses data_valid. The consumer decides whether to discard it.
- Back-to-back frames: a start bit on the cycle immediately after the stop bit is accepted. The data_valid pulse of the previous frame does not block it.
- Reset mid-frame aborts the frame. No data_valid is produced and the previous data_out is cleared to 0.
- Counter width is $clog2(DATA_W)+1. No wrap-around beyond DATA_W bits is possible.

Decomposition:
- Shared package: state encoding localparams (IDLE=2'd0, DATA=2'd1, PARITY=2'd2, STOP=2'd3) and the ODD/EVEN parity constants. The matching transmitter uses the same package.
- One sub-module, xor_accumulator:
  - 1-bit register with clear, enable and d inputs.
  - acc <= clr ? 0 : en ? acc ^ d : acc.
  - Reused by the transmitter's parity generator.

Test Plan:
- Reset: hold rst for 2 cycles -> all outputs 0, busy=0; rx_valid pulses with rx_bit=1 -> busy stays 0.
- Good frame, DATA_W=8, even parity:
  - Stimulus: start 0; data 0xA5 sent LSB first as 1,0,1,0,0,1,0,1; parity 0; stop 1; rx_valid continuous.
  - Response: data_valid high for 1 cycle, data_out=0xA5, parity_err=0, frame_err=0.
- Error frames:
  - Same frame with parity bit 1 -> parity_err=1, data_out=0xA5.
  - Frame 0x07 with parity 1 and stop 0 -> parity_err=0, frame_err=1, data_out=0x07.
- Gapped strobes: frame 0x3C, parity 0, with rx_valid low for 3 cycles between every bit -> same result as the continuous case; busy stays high throughout the gaps.
- Reset mid-frame: assert rst after 4 data bits of 0xFF -> no data_valid, busy=0, data_out=0. A following full 0x3C frame is received correctly.
- Back-to-back and odd parity, ODD_PARITY=1:
  - 0xA5 with parity 1, then immediately 0x01 with parity 0 -> two data_valid pulses, data_out 0xA5 then 0x01, both with parity_err=0.
  - 0xA5 with parity 0 -> parity_err=1.

Source files
------------

// File: rtl/serial_parity_checker_pkg.sv
// serial_parity_checker_pkg: state encoding and parity constants shared by the link's receiver and transmitter.
package serial_parity_checker_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;
  localparam bit PARITY_EVEN = 1'b0;
  localparam bit PARITY_ODD  = 1'b1;
endpackage

// File: rtl/serial_parity_checker_xor_accumulator.sv
// xor_accumulator: 1-bit running XOR with clear and enable, clear taking priority.
module xor_accumulator (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic acc
);
  always_ff @(posedge clk)
    acc <= (rst || clr) ? 1'b0 : en ? acc ^ d : acc;
endmodule

// File: rtl/serial_parity_checker.sv
// serial_parity_checker: deserialises start/data/parity/stop frames and flags parity and framing errors.
module serial_parity_checker
  import serial_parity_checker_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter bit ODD_PARITY = PARITY_EVEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_bit,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);
  localparam int CW = $clog2(DATA_W) + 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
  state_t            state;
  logic [DATA_W-1:0] sreg;
  logic [CW-1:0]     cnt;
  logic              perr;
  logic              acc;
  xor_accumulator u_acc (
    .clk (clk),
    .rst (rst),
    .clr (rx_valid && state == IDLE && !rx_bit),
    .en  (rx_valid && state == DATA),
    .d   (rx_bit),
    .acc (acc)
  );
  assign busy = state != IDLE;
  // sreg is cleared on the start bit, so OR-ing each bit into place is enough
  always_ff @(posedge clk)
    if (rst) begin
      state      <= IDLE;
      sreg       <= '0;
      cnt        <= '0;
      perr       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= rx_valid && state == STOP;
      if (rx_valid)
        case (state)
          IDLE: if (!rx_bit) begin
            sreg  <= '0;
            cnt   <= '0;
            state <= DATA;
          end
          DATA: begin
            sreg <= sreg | (DATA_W'(rx_bit) << cnt);
            cnt  <= cnt + 1'b1;
            if (cnt == LAST) state <= PARITY;
          end
          PARITY: begin
            perr  <= acc ^ rx_bit ^ ODD_PARITY;
            state <= STOP;
          end
          STOP: begin
            data_out   <= sreg;
            parity_err <= perr;
            frame_err  <= ~rx_bit;
            state      <= IDLE;
          end
        endcase
    end
endmodule
